mlp_layer_sequencer: RTL and testbench
======================================

// Module: mlp_layer_sequencer
// PURPOSE
//  Sequences one fully-connected MLP layer over a shared external MAC unit:
//  walks input/weight memories neuron by neuron, requantises each accumulator
//  to Q8.8 and writes it to the output buffer. Also tracks the argmax class.
//  Sits between the 784x16b input image buffer, the weight ROM and the
//  10x16b result buffer of the handwriting network.
// PARAMETERS
//  N_IN   784  inputs per neuron (>=2)
//  N_OUT  10   neurons in layer (>=1)
//  DW     16   signed data width, Q8.8
//  ACC_W  40   width of MAC accumulator result
//  FRAC   8    fractional bits removed on requantisation
//  (localparams: IAW=$clog2(N_IN), WAW=$clog2(N_IN*N_OUT), OAW=$clog2(N_OUT), min 1)
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      synchronous, active-high
//  start       in   1      begin layer; sampled in IDLE only
//  abort       in   1      cancel run, back to IDLE, no done
//  busy        out  1      high in any state except IDLE
//  done        out  1      one-cycle pulse, layer complete
//  rd_en       out  1      read strobe to input buffer and weight ROM
//  in_addr     out  IAW    input buffer address
//  w_addr      out  WAW    weight address = neuron*N_IN + i
//  mac_clr     out  1      MAC: load product instead of accumulate
//  mac_en      out  1      MAC: operands valid this cycle
//  acc_result  in   ACC_W  signed MAC accumulator, valid 1 cycle after last mac_en
//  out_wr_en   out  1      write strobe to result buffer
//  out_addr    out  OAW    result index (neuron number)
//  out_data    out  DW     requantised neuron output
//  class_idx   out  OAW    argmax of outputs, valid when done pulses, held until next start
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, rd_en, mac_clr, mac_en, out_wr_en = 0;
//   in_addr, w_addr, out_addr, out_data, class_idx = 0; best value = most negative.
//  FSM: IDLE -start-> RUN -(i==N_IN-1)-> FLUSH(2 cyc) -> WRITE
//   -> RUN (next neuron) | DONE (last neuron) -> IDLE.
//  RUN: rd_en=1, in_addr=i, w_addr=n*N_IN+i; i increments each cycle.
//  Memory latency 1: mac_en = rd_en delayed 1 cycle; mac_clr = 1 with first mac_en of neuron.
//  FLUSH cycle 1 carries last mac_en; acc_result sampled at end of FLUSH cycle 2.
//  WRITE: out_wr_en=1, out_addr=n, out_data=sat_DW(acc_result >>> FRAC)
//   (arithmetic shift, truncate toward -inf, saturate to [-2^(DW-1), 2^(DW-1)-1]).
//  Argmax: compare post-requantisation out_data; strictly greater replaces, so
//   ties keep the lowest index; neuron 0 always initialises.
//  Cycles per neuron N_IN+3; done asserted N_OUT*(N_IN+3)+1 cycles after the
//   start-sampling edge (7871 for defaults); busy low again the cycle after done.
//  start while busy: ignored. start and abort together in IDLE: abort wins, stay IDLE.
//  abort in any busy state: next cycle IDLE, all strobes low, no done, no
//   further out_wr_en; class_idx keeps previous value.
//  reset mid-run: identical to reset values above; external buffers untouched.
//  Address counters never wrap: i stops at N_IN-1, n at N_OUT-1.
// CONFIGURATION
//  MLP_SEQ_RELU_EN defined: out_data = max(0, sat value); argmax uses ReLU value.
//  Undefined: out_data is signed saturated value, negatives pass through.
// TESTING (bench uses N_IN=4, N_OUT=3, behavioural MAC + memories)
//  1. x=all 1.0(0x0100), w rows {1,1,1,1},{2,..},{-1,..} -> out 0x0400,0x0800,
//     0xFC00 (0x0000 with RELU_EN), class_idx=1, done at cycle 22.
//  2. Weights 127.0 everywhere, x=127.0 -> out_data saturates 0x7FFF for all; class_idx=0 (tie).
//  3. Pulse start at cycles 1..5 of a run -> single run, exactly 3 out_wr_en, one done.
//  4. abort during neuron 1 RUN -> IDLE next cycle, no done, only out_addr 0 written.
//  5. reset asserted in FLUSH -> all outputs to reset values next cycle; new start runs clean.
//  6. Check rd_en/in_addr/w_addr sequence 0..3, 4..7, 8..11 and mac_en lagging rd_en by 1.

Source files
------------

// File: rtl/mlp_layer_sequencer.sv
// Sequences one fully-connected layer over an external MAC, requantises each neuron to Q8.8 and tracks argmax.
// Optional build macro MLP_SEQ_RELU_EN clamps outputs (and the argmax input) at zero.
module mlp_layer_sequencer #(
    parameter int N_IN  = 784,
    parameter int N_OUT = 10,
    parameter int DW    = 16,
    parameter int ACC_W = 40,
    parameter int FRAC  = 8,
    localparam int IAW = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int WAW = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    localparam int OAW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [IAW-1:0]   in_addr,
    output logic [WAW-1:0]   w_addr,
    output logic             mac_clr,
    output logic             mac_en,
    input  logic [ACC_W-1:0] acc_result,
    output logic             out_wr_en,
    output logic [OAW-1:0]   out_addr,
    output logic [DW-1:0]    out_data,
    output logic [OAW-1:0]   class_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH1,
        S_FLUSH2,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [IAW-1:0]       I_LAST   = IAW'(N_IN - 1);
    localparam logic [OAW-1:0]       N_LAST   = OAW'(N_OUT - 1);
    localparam logic signed [DW-1:0] DATA_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] DATA_MIN = {1'b1, {(DW-1){1'b0}}};

    state_t                 state_q, state_d;
    logic [IAW-1:0]         i_q, i_d;
    logic [OAW-1:0]         n_q, n_d;
    logic [WAW-1:0]         w_q, w_d;
    logic                   mac_en_q, mac_en_d;
    logic                   mac_clr_q, mac_clr_d;
    logic signed [DW-1:0]   out_data_q, out_data_d;
    logic signed [DW-1:0]   best_q, best_d;
    logic [OAW-1:0]         cand_q, cand_d;
    logic [OAW-1:0]         class_idx_q, class_idx_d;

    logic signed [ACC_W-1:0] acc_shifted;
    logic                    in_range;
    logic signed [DW-1:0]    sat_val;
    logic signed [DW-1:0]    act_val;
    logic                    take_new;
    logic [OAW-1:0]          cand_next;

    // Requantise: floor shift, then saturate if the bits above the DW-bit sign are not all sign copies.
    always_comb begin
        acc_shifted = $signed(acc_result) >>> FRAC;
        in_range    = (acc_shifted[ACC_W-1:DW-1] == '0) || (acc_shifted[ACC_W-1:DW-1] == '1);
        if (in_range) begin
            sat_val = acc_shifted[DW-1:0];
        end else if (acc_shifted[ACC_W-1]) begin
            sat_val = DATA_MIN;
        end else begin
            sat_val = DATA_MAX;
        end
`ifdef MLP_SEQ_RELU_EN
        act_val = sat_val[DW-1] ? '0 : sat_val;
`else
        act_val = sat_val;
`endif
    end

    always_comb begin
        take_new  = (n_q == '0) || (out_data_q > best_q);
        cand_next = take_new ? n_q : cand_q;
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        n_d         = n_q;
        w_d         = w_q;
        out_data_d  = out_data_q;
        best_d      = best_q;
        cand_d      = cand_q;
        class_idx_d = class_idx_q;
        // Memory has one cycle of latency, so the MAC strobes trail the read strobe.
        mac_en_d    = (state_q == S_RUN) && !abort;
        mac_clr_d   = (state_q == S_RUN) && (i_q == '0) && !abort;

        if (abort) begin
            state_d = S_IDLE;
            i_d     = '0;
            n_d     = '0;
            w_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        i_d     = '0;
                        n_d     = '0;
                        w_d     = '0;
                        best_d  = DATA_MIN;
                    end
                end
                S_RUN: begin
                    if (i_q == I_LAST) begin
                        state_d = S_FLUSH1;
                    end else begin
                        i_d = i_q + 1'b1;
                        w_d = w_q + 1'b1;
                    end
                end
                S_FLUSH1: state_d = S_FLUSH2;
                S_FLUSH2: begin
                    state_d    = S_WRITE;
                    out_data_d = act_val;
                end
                S_WRITE: begin
                    if (take_new) begin
                        best_d = out_data_q;
                    end
                    cand_d = cand_next;
                    if (n_q == N_LAST) begin
                        state_d     = S_DONE;
                        class_idx_d = cand_next;
                    end else begin
                        state_d = S_RUN;
                        n_d     = n_q + 1'b1;
                        i_d     = '0;
                        w_d     = w_q + 1'b1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            n_q         <= '0;
            w_q         <= '0;
            mac_en_q    <= 1'b0;
            mac_clr_q   <= 1'b0;
            out_data_q  <= '0;
            best_q      <= DATA_MIN;
            cand_q      <= '0;
            class_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            n_q         <= n_d;
            w_q         <= w_d;
            mac_en_q    <= mac_en_d;
            mac_clr_q   <= mac_clr_d;
            out_data_q  <= out_data_d;
            best_q      <= best_d;
            cand_q      <= cand_d;
            class_idx_q <= class_idx_d;
        end
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        rd_en     = (state_q == S_RUN);
        out_wr_en = (state_q == S_WRITE);
        in_addr   = i_q;
        w_addr    = w_q;
        out_addr  = n_q;
        out_data  = out_data_q;
        class_idx = class_idx_q;
        mac_en    = mac_en_q;
        mac_clr   = mac_clr_q;
    end

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Bench for mlp_layer_sequencer with behavioural memories and MAC; expected result-buffer
// writes are queued from a reference model of the layer and matched against observed writes.
module tb_mlp_layer_sequencer;
    localparam int N_IN  = 4;
    localparam int N_OUT = 3;
    localparam int DW    = 16;
    localparam int ACC_W = 40;
    localparam int FRAC  = 8;
    localparam int IAW   = 2;
    localparam int WAW   = 4;
    localparam int OAW   = 2;
    localparam int RUN_CYCLES = N_OUT * (N_IN + 3) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             busy, done, rd_en, mac_clr, mac_en, out_wr_en;
    logic [IAW-1:0]   in_addr;
    logic [WAW-1:0]   w_addr;
    logic [OAW-1:0]   out_addr, class_idx;
    logic [DW-1:0]    out_data;
    logic [ACC_W-1:0] acc_result;

    typedef struct packed {
        logic [OAW-1:0] a;
        logic [DW-1:0]  d;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  tests_run = 0;
    int  fails     = 0;
    int  cyc       = 0;
    int  done_cnt  = 0;
    int  done_cyc  = 0;
    int  exp_class = 0;

    logic signed [DW-1:0]    x_mem [N_IN];
    logic signed [DW-1:0]    w_mem [N_IN*N_OUT];
    logic signed [DW-1:0]    x_rd = '0;
    logic signed [DW-1:0]    w_rd = '0;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] acc = '0;

    always #5 clk = ~clk;

    mlp_layer_sequencer #(
        .N_IN (N_IN),
        .N_OUT(N_OUT),
        .DW   (DW),
        .ACC_W(ACC_W),
        .FRAC (FRAC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .in_addr   (in_addr),
        .w_addr    (w_addr),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .acc_result(acc_result),
        .out_wr_en (out_wr_en),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .class_idx (class_idx)
    );

    assign prod       = x_rd * w_rd;
    assign acc_result = acc;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en === 1'b1) begin
            x_rd <= x_mem[in_addr];
            w_rd <= w_mem[w_addr];
        end
        if (mac_en === 1'b1) acc <= mac_clr ? ACC_W'(prod) : acc + ACC_W'(prod);
    end

    always @(negedge clk) begin
        if (out_wr_en === 1'b1) obs_q.push_back(wr_t'({out_addr, out_data}));
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_rows(input logic [DW-1:0] xv, input logic [DW-1:0] r0,
                             input logic [DW-1:0] r1, input logic [DW-1:0] r2);
        for (int i = 0; i < N_IN; i++) begin
            x_mem[i]          = xv;
            w_mem[i]          = r0;
            w_mem[N_IN + i]   = r1;
            w_mem[2*N_IN + i] = r2;
        end
    endtask

    // Reference layer: exact integer dot product, floor shift, clamp, optional ReLU.
    task automatic push_expected(input int rows);
        longint s, q, best;
        logic [DW-1:0] dq;
        best = 0;
        for (int n = 0; n < N_OUT; n++) begin
            s = 0;
            for (int i = 0; i < N_IN; i++) s += longint'(x_mem[i]) * longint'(w_mem[n*N_IN + i]);
            q = s >>> FRAC;
            if (q > 32767) q = 32767;
            else if (q < -32768) q = -32768;
`ifdef MLP_SEQ_RELU_EN
            if (q < 0) q = 0;
`endif
            dq = q[DW-1:0];
            if (n < rows) exp_q.push_back(wr_t'{a: OAW'(n), d: dq});
            if (n == 0 || q > best) begin
                best      = q;
                exp_class = n;
            end
        end
    endtask

    task automatic start_run(output int c0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        c0 = cyc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        tests_run++;
        if ({busy, done, rd_en, mac_clr, mac_en, out_wr_en} !== 6'b0) begin
            fails++;
            $display("FAIL reset_strobes: got %b, want 000000", {busy, done, rd_en, mac_clr, mac_en, out_wr_en});
        end
        tests_run++;
        if ({in_addr, w_addr, out_addr, out_data, class_idx} !== '0) begin
            fails++;
            $display("FAIL reset_values: got in %0d w %0d oa %0d od %h cls %0d, want all 0",
                     in_addr, w_addr, out_addr, out_data, class_idx);
        end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_basic();
        int c0, base;
        wr_t e, o;
        load_rows(16'h0100, 16'h0100, 16'h0200, 16'hFF00);
        push_expected(N_OUT);
        base = done_cnt;
        start_run(c0);
        for (int k = 0; k < 60 && done_cnt == base; k++) tick(1);
        tests_run++;
        if (done_cnt - base != 1) begin fails++; $display("FAIL basic_done: got %0d pulses, want 1", done_cnt - base); end
        tests_run++;
        if (done_cyc - c0 + 1 != 22) begin fails++; $display("FAIL basic_latency: got %0d, want 22", done_cyc - c0 + 1); end
        tests_run++;
        if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after_done: got %b, want 0", busy); end
        tests_run++;
        if (class_idx !== 2'd1) begin fails++; $display("FAIL basic_class: got %0d, want 1", class_idx); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL basic_write: got none, want addr %0d data %h", e.a, e.d);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL basic_write: got addr %0d data %h, want addr %0d data %h", o.a, o.d, e.a, e.d); end
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin fails++; $display("FAIL basic_extra_writes: got %0d extra, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_addr_sequence();
        int c0, exp_w;
        logic exp_rd, prev_rd, prev_first;
        load_rows(16'h0100, 16'h0100, 16'h0200, 16'hFF00);
        exp_w      = 0;
        prev_rd    = 1'b0;
        prev_first = 1'b0;
        start_run(c0);
        for (int t = 0; t <= RUN_CYCLES; t++) begin
            exp_rd = (t < N_OUT * (N_IN + 3)) && ((t % (N_IN + 3)) < N_IN);
            tests_run++;
            if (rd_en !== exp_rd || mac_en !== prev_rd || mac_clr !== prev_first) begin
                fails++;
                $display("FAIL seq_strobes t=%0d: got rd %b mac_en %b mac_clr %b, want %b %b %b",
                         t, rd_en, mac_en, mac_clr, exp_rd, prev_rd, prev_first);
            end
            if (exp_rd) begin
                tests_run++;
                if (in_addr !== IAW'(exp_w % N_IN) || w_addr !== WAW'(exp_w)) begin
                    fails++;
                    $display("FAIL seq_addr t=%0d: got in %0d w %0d, want in %0d w %0d",
                             t, in_addr, w_addr, exp_w % N_IN, exp_w);
                end
                exp_w++;
            end
            prev_rd    = exp_rd;
            prev_first = exp_rd && ((t % (N_IN + 3)) == 0);
            tick(1);
        end
        tick(2);
        obs_q.delete();
    endtask

    task automatic test_saturation();
        int c0, base;
        wr_t e, o;
        for (int p = 0; p < 2; p++) begin
            if (p == 0) load_rows(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00);
            else        load_rows(16'h8000, 16'h7F00, 16'h8000, 16'h0000);
            push_expected(N_OUT);
            base = done_cnt;
            start_run(c0);
            for (int k = 0; k < 60 && done_cnt == base; k++) tick(1);
            tests_run++;
            if (done_cnt - base != 1) begin fails++; $display("FAIL sat%0d_done: got %0d pulses, want 1", p, done_cnt - base); end
            tests_run++;
            if (class_idx !== OAW'(exp_class)) begin fails++; $display("FAIL sat%0d_class: got %0d, want %0d", p, class_idx, exp_class); end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests_run++;
                if (obs_q.size() == 0) begin
                    fails++; $display("FAIL sat%0d_write: got none, want addr %0d data %h", p, e.a, e.d);
                end else begin
                    o = obs_q.pop_front();
                    if (o !== e) begin fails++; $display("FAIL sat%0d_write: got addr %0d data %h, want addr %0d data %h", p, o.a, o.d, e.a, e.d); end
                end
            end
            tests_run++;
            if (obs_q.size() != 0) begin fails++; $display("FAIL sat%0d_extra_writes: got %0d extra, want 0", p, obs_q.size()); obs_q.delete(); end
        end
    endtask

    task automatic test_start_ignored();
        int base;
        wr_t e, o;
        load_rows(16'h0100, 16'h0100, 16'h0200, 16'hFF00);
        push_expected(N_OUT);
        base  = done_cnt;
        start = 1'b1;
        tick(6);
        start = 1'b0;
        for (int k = 0; k < 60 && done_cnt == base; k++) tick(1);
        tick(10);
        tests_run++;
        if (done_cnt - base != 1) begin fails++; $display("FAIL startign_done: got %0d pulses, want 1", done_cnt - base); end
        tests_run++;
        if (busy !== 1'b0) begin fails++; $display("FAIL startign_busy: got %b, want 0", busy); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL startign_write: got none, want addr %0d data %h", e.a, e.d);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL startign_write: got addr %0d data %h, want addr %0d data %h", o.a, o.d, e.a, e.d); end
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin fails++; $display("FAIL startign_extra_writes: got %0d extra, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_abort();
        int c0, base, prev_class;
        wr_t e, o;
        prev_class = exp_class;
        load_rows(16'h0100, 16'h0300, 16'h0200, 16'h0100);
        push_expected(1);
        base = done_cnt;
        start_run(c0);
        tick(8);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tests_run++;
        if ({busy, rd_en, mac_en, mac_clr, out_wr_en} !== 5'b0) begin
            fails++; $display("FAIL abort_idle: got busy/rd/mac_en/mac_clr/wr %b, want 00000", {busy, rd_en, mac_en, mac_clr, out_wr_en});
        end
        tick(30);
        tests_run++;
        if (done_cnt != base) begin fails++; $display("FAIL abort_no_done: got %0d pulses, want 0", done_cnt - base); end
        tests_run++;
        if (class_idx !== OAW'(prev_class)) begin fails++; $display("FAIL abort_class_held: got %0d, want %0d", class_idx, prev_class); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL abort_write: got none, want addr %0d data %h", e.a, e.d);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL abort_write: got addr %0d data %h, want addr %0d data %h", o.a, o.d, e.a, e.d); end
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin fails++; $display("FAIL abort_extra_writes: got %0d extra, want 0", obs_q.size()); obs_q.delete(); end
        exp_class = prev_class;
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin fails++; $display("FAIL abort_beats_start: got busy %b, want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int c0, base;
        wr_t e, o;
        load_rows(16'h0080, 16'h0100, 16'hFE00, 16'h0300);
        start_run(c0);
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tests_run++;
        if ({busy, done, rd_en, mac_clr, mac_en, out_wr_en} !== 6'b0) begin
            fails++; $display("FAIL midreset_strobes: got %b, want 000000", {busy, done, rd_en, mac_clr, mac_en, out_wr_en});
        end
        tests_run++;
        if ({in_addr, w_addr, out_addr, out_data, class_idx} !== '0) begin
            fails++;
            $display("FAIL midreset_values: got in %0d w %0d oa %0d od %h cls %0d, want all 0",
                     in_addr, w_addr, out_addr, out_data, class_idx);
        end
        push_expected(N_OUT);
        base = done_cnt;
        start_run(c0);
        for (int k = 0; k < 60 && done_cnt == base; k++) tick(1);
        tests_run++;
        if (done_cnt - base != 1) begin fails++; $display("FAIL midreset_done: got %0d pulses, want 1", done_cnt - base); end
        tests_run++;
        if (class_idx !== 2'd2) begin fails++; $display("FAIL midreset_class: got %0d, want 2", class_idx); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL midreset_write: got none, want addr %0d data %h", e.a, e.d);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL midreset_write: got addr %0d data %h, want addr %0d data %h", o.a, o.d, e.a, e.d); end
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin fails++; $display("FAIL midreset_extra_writes: got %0d extra, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_back_to_back();
        int c0, base, v;
        wr_t e, o;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N_IN; i++) begin
                v = int'($urandom_range(2047)) - 1024;
                x_mem[i] = v[DW-1:0];
            end
            for (int j = 0; j < N_IN * N_OUT; j++) begin
                v = int'($urandom_range(2047)) - 1024;
                w_mem[j] = v[DW-1:0];
            end
            push_expected(N_OUT);
            base = done_cnt;
            start_run(c0);
            for (int k = 0; k < 60 && done_cnt == base; k++) tick(1);
            tests_run++;
            if (done_cnt - base != 1 || done_cyc - c0 + 1 != RUN_CYCLES) begin
                fails++; $display("FAIL b2b%0d_done: got %0d pulses at cycle %0d, want 1 at %0d", r, done_cnt - base, done_cyc - c0 + 1, RUN_CYCLES);
            end
            tests_run++;
            if (class_idx !== OAW'(exp_class)) begin fails++; $display("FAIL b2b%0d_class: got %0d, want %0d", r, class_idx, exp_class); end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests_run++;
                if (obs_q.size() == 0) begin
                    fails++; $display("FAIL b2b%0d_write: got none, want addr %0d data %h", r, e.a, e.d);
                end else begin
                    o = obs_q.pop_front();
                    if (o !== e) begin fails++; $display("FAIL b2b%0d_write: got addr %0d data %h, want addr %0d data %h", r, o.a, o.d, e.a, e.d); end
                end
            end
            tests_run++;
            if (obs_q.size() != 0) begin fails++; $display("FAIL b2b%0d_extra_writes: got %0d extra, want 0", r, obs_q.size()); obs_q.delete(); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_addr_sequence();
        test_saturation();
        test_start_ignored();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
